// File: rtl/harvard_bus_arbiter.sv
// Round-robin arbiter sharing one wait-state memory bus between the CPU
// instruction-fetch port and data port, with registered bus outputs and optional timeout.
module harvard_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TCNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  output logic        instr_done,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writedata,
  input  logic [3:0]  data_byteenable,
  output logic [31:0] data_readdata,
  output logic        data_done,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic               last_data_r, last_data_s;
  logic [TCNT_W-1:0]  tcnt_r, tcnt_s;

  logic [31:0] address_s, writedata_s, instr_readdata_s, data_readdata_s;
  logic        read_s, write_s, instr_done_s, data_done_s, bus_error_s;
  logic [3:0]  byteenable_s;

  logic i_want_s, d_want_s, grant_i_s, grant_d_s, timeout_hit_s;

  // Arbitration and grant decode; a side whose done is high is masked so its
  // still-held request is not re-granted.
  always_comb begin
    i_want_s      = instr_req & ~instr_done;
    d_want_s      = (data_read | data_write) & ~data_done;
    grant_i_s     = i_want_s & (~d_want_s | last_data_r);
    grant_d_s     = d_want_s & (~i_want_s | ~last_data_r);
    timeout_hit_s = (TIMEOUT_CYCLES > 0) && (tcnt_r == TCNT_W'(TIMEOUT_CYCLES));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s          = state_r;
    last_data_s      = last_data_r;
    tcnt_s           = tcnt_r;
    address_s        = address;
    read_s           = read;
    write_s          = write;
    writedata_s      = writedata;
    byteenable_s     = byteenable;
    instr_readdata_s = instr_readdata;
    data_readdata_s  = data_readdata;
    instr_done_s     = 1'b0;
    data_done_s      = 1'b0;
    bus_error_s      = 1'b0;

    case (state_r)
      IDLE: begin
        tcnt_s = {TCNT_W{1'b0}};
        if (grant_i_s) begin
          state_s      = BUS_I;
          last_data_s  = 1'b0;
          address_s    = instr_address;
          read_s       = 1'b1;
          write_s      = 1'b0;
          byteenable_s = 4'b1111;
        end else if (grant_d_s) begin
          state_s      = BUS_D;
          last_data_s  = 1'b1;
          address_s    = data_address;
          writedata_s  = data_writedata;
          byteenable_s = data_byteenable;
          // A store wins over a simultaneous load request.
          read_s       = ~data_write;
          write_s      = data_write;
        end else begin
          state_s = IDLE;
        end
      end

      BUS_I, BUS_D: begin
        if (!waitrequest || timeout_hit_s) begin
          state_s     = IDLE;
          read_s      = 1'b0;
          write_s     = 1'b0;
          tcnt_s      = {TCNT_W{1'b0}};
          bus_error_s = waitrequest;
          if (state_r == BUS_I) begin
            instr_done_s     = 1'b1;
            instr_readdata_s = waitrequest ? 32'h0000_0000 : readdata;
          end else begin
            data_done_s = 1'b1;
            if (read) begin
              data_readdata_s = waitrequest ? 32'h0000_0000 : readdata;
            end else begin
              data_readdata_s = data_readdata;
            end
          end
        end else begin
          // Saturate so a disabled timeout never wraps into a false match.
          if (tcnt_r == {TCNT_W{1'b1}}) begin
            tcnt_s = tcnt_r;
          end else begin
            tcnt_s = tcnt_r + {{(TCNT_W-1){1'b0}}, 1'b1};
          end
        end
      end

      default: begin
        state_s = IDLE;
        read_s  = 1'b0;
        write_s = 1'b0;
        tcnt_s  = {TCNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      last_data_r    <= 1'b1;
      tcnt_r         <= {TCNT_W{1'b0}};
      address        <= 32'h0000_0000;
      read           <= 1'b0;
      write          <= 1'b0;
      writedata      <= 32'h0000_0000;
      byteenable     <= 4'b0000;
      instr_readdata <= 32'h0000_0000;
      data_readdata  <= 32'h0000_0000;
      instr_done     <= 1'b0;
      data_done      <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      state_r        <= state_s;
      last_data_r    <= last_data_s;
      tcnt_r         <= tcnt_s;
      address        <= address_s;
      read           <= read_s;
      write          <= write_s;
      writedata      <= writedata_s;
      byteenable     <= byteenable_s;
      instr_readdata <= instr_readdata_s;
      data_readdata  <= data_readdata_s;
      instr_done     <= instr_done_s;
      data_done      <= data_done_s;
      bus_error      <= bus_error_s;
    end
  end

endmodule

// File: tb/tb_harvard_bus_arbiter.sv
// Scoreboard bench for harvard_bus_arbiter: directed requests push expected bus
// transactions and completions; negedge monitors model the memory and compare.
module tb_harvard_bus_arbiter;

  logic        clk, reset;
  logic        instr_req, instr_done;
  logic [31:0] instr_address, instr_readdata;
  logic        data_read, data_write, data_done;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic [3:0]  data_byteenable;
  logic        bus_error;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  harvard_bus_arbiter #(.TIMEOUT_CYCLES(8), .TCNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_done(instr_done),
    .data_read(data_read), .data_write(data_write), .data_address(data_address),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_done(data_done), .bus_error(bus_error),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        chk_wd;
    int          waits;
    int          hi_exp;
    logic [31:0] rdata;
  } bus_txn_t;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        err;
  } cpl_t;

  bus_txn_t bus_q[$];
  cpl_t     cpl_q[$];
  int       n_checks = 0;
  int       n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input logic [3:0] be, input logic cwd,
                          input int waits, input int hi_exp, input logic [31:0] rdata);
    bus_txn_t t;
    t.addr = a; t.rd = rd; t.wr = wr; t.wdata = wd; t.be = be; t.chk_wd = cwd;
    t.waits = waits; t.hi_exp = hi_exp; t.rdata = rdata;
    bus_q.push_back(t);
  endtask

  task automatic push_cpl(input logic is_data, input logic [31:0] rdata, input logic err);
    cpl_t c;
    c.is_data = is_data; c.rdata = rdata; c.err = err;
    cpl_q.push_back(c);
  endtask

  // Memory model and bus checker.
  bus_txn_t cur;
  logic     have_cur = 1'b0;
  logic     prev_strobe = 1'b0;
  int       hi_cnt = 0;

  always @(negedge clk) begin
    if ((read | write) && !prev_strobe) begin
      hi_cnt = 0;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
        have_cur = 1'b0;
      end else begin
        cur = bus_q.pop_front();
        have_cur = 1'b1;
      end
    end
    if ((read | write) && have_cur) begin
      hi_cnt++;
      chk("bus_address", address, cur.addr);
      chk("bus_read", {31'd0, read}, {31'd0, cur.rd});
      chk("bus_write", {31'd0, write}, {31'd0, cur.wr});
      chk("bus_byteenable", {28'd0, byteenable}, {28'd0, cur.be});
      if (cur.chk_wd) chk("bus_writedata", writedata, cur.wdata);
      waitrequest = (hi_cnt <= cur.waits);
      readdata    = cur.rdata;
    end else if (!(read | write) && prev_strobe && have_cur) begin
      if (cur.hi_exp != 0) chk("bus_hold_cycles", hi_cnt, cur.hi_exp);
      have_cur    = 1'b0;
      waitrequest = 1'b0;
      readdata    = 32'h0;
    end else if (!(read | write)) begin
      waitrequest = 1'b0;
      readdata    = 32'h0;
    end
    prev_strobe = read | write;
  end

  // Completion monitor.
  always @(negedge clk) begin
    cpl_t c;
    if (instr_done || data_done) begin
      if (cpl_q.size() == 0) begin
        chk("done_unexpected", {30'd0, instr_done, data_done}, 32'd0);
      end else begin
        c = cpl_q.pop_front();
        chk("done_side", {30'd0, instr_done, data_done}, c.is_data ? 32'd1 : 32'd2);
        if (c.is_data) chk("data_readdata", data_readdata, c.rdata);
        else           chk("instr_readdata", instr_readdata, c.rdata);
        chk("bus_error", {31'd0, bus_error}, {31'd0, c.err});
        chk("strobes_low_on_done", {30'd0, read, write}, 32'd0);
      end
    end else if (bus_error) begin
      chk("bus_error_without_done", {31'd0, bus_error}, 32'd0);
    end
  end

  task automatic run(input bit do_i, input int i_delay, input bit do_d,
                     input bit drd, input bit dwr);
    int cyc;
    bit i_pend, d_pend;
    @(negedge clk);
    cyc = 0; i_pend = do_i; d_pend = do_d;
    if (do_d) begin data_read = drd; data_write = dwr; end
    if (do_i && i_delay == 0) instr_req = 1'b1;
    while ((i_pend || d_pend) && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (i_pend && instr_done) begin instr_req = 1'b0; i_pend = 1'b0; end
      if (d_pend && data_done) begin data_read = 1'b0; data_write = 1'b0; d_pend = 1'b0; end
      if (do_i && i_pend && cyc == i_delay) instr_req = 1'b1;
    end
    chk("run_complete", {31'd0, i_pend | d_pend}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1; instr_req = 1'b0; instr_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; data_address = 32'h0;
    data_writedata = 32'h0; data_byteenable = 4'h0;
    waitrequest = 1'b0; readdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_address", address, 32'h0);
    chk("rst_strobes", {30'd0, read, write}, 32'd0);
    chk("rst_byteenable_writedata", {writedata[27:0], byteenable}, 32'd0);
    chk("rst_dones", {29'd0, instr_done, data_done, bus_error}, 32'd0);
    chk("rst_instr_readdata", instr_readdata, 32'h0);
    chk("rst_data_readdata", data_readdata, 32'h0);
    reset = 1'b0;

    // Single fetch, zero waits.
    instr_address = 32'hBFC0_0000;
    push_bus(32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h2402_0005);
    push_cpl(1'b0, 32'h2402_0005, 1'b0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Tie right after reset: fetch first, then data.
    do_reset();
    instr_address = 32'h0000_0100; data_address = 32'h0000_1000;
    data_byteenable = 4'b1111; data_writedata = 32'h0;
    push_bus(32'h0000_0100, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h1111_1111);
    push_bus(32'h0000_1000, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 0, 1, 32'hCAFE_F00D);
    push_cpl(1'b0, 32'h1111_1111, 1'b0);
    push_cpl(1'b1, 32'hCAFE_F00D, 1'b0);
    run(1'b1, 0, 1'b1, 1'b1, 1'b0);

    // Lone fetch leaves fetch as last grant.
    instr_address = 32'h0000_0104;
    push_bus(32'h0000_0104, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1, 2, 32'h2222_2222);
    push_cpl(1'b0, 32'h2222_2222, 1'b0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0);

    // Tie again: data wins this time.
    instr_address = 32'h0000_0108; data_address = 32'h0000_1004;
    push_bus(32'h0000_1004, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 0, 1, 32'h4444_4444);
    push_bus(32'h0000_0108, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 0, 1, 32'h3333_3333);
    push_cpl(1'b1, 32'h4444_4444, 1'b0);
    push_cpl(1'b0, 32'h3333_3333, 1'b0);
    run(1'b1, 0, 1'b1, 1'b1, 1'b0);

    // Store with three wait states; data_readdata keeps the last load value.
    data_address = 32'h0000_2004; data_writedata = 32'hDEAD_BEEF; data_byteenable = 4'b0011;
    push_bus(32'h0000_2004, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b1, 3, 4, 32'h0BAD_0BAD);
    push_cpl(1'b1, 32'h4444_4444, 1'b0);
    run(1'b0, 0, 1'b1, 1'b0, 1'b1);

    // Read and write both requested: only the write reaches the bus.
    data_address = 32'h0000_3000; data_writedata = 32'h1234_5678; data_byteenable = 4'b1100;
    push_bus(32'h0000_3000, 1'b0, 1'b1, 32'h1234_5678, 4'b1100, 1'b1, 1, 2, 32'h0BAD_0BAD);
    push_cpl(1'b1, 32'h4444_4444, 1'b0);
    run(1'b0, 0, 1'b1, 1'b1, 1'b1);

    // Stuck load times out after 8 waits; a fetch raised meanwhile is served next.
    data_address = 32'h0000_4000; data_writedata = 32'h0; data_byteenable = 4'b1111;
    instr_address = 32'h0000_0200;
    push_bus(32'h0000_4000, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 1000, 9, 32'hABCD_0000);
    push_bus(32'h0000_0200, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 2, 3, 32'h5555_5555);
    push_cpl(1'b1, 32'h0, 1'b1);
    push_cpl(1'b0, 32'h5555_5555, 1'b0);
    run(1'b1, 3, 1'b1, 1'b1, 1'b0);

    // Reset while a stalled load is on the bus.
    data_address = 32'h0000_5000;
    push_bus(32'h0000_5000, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 1000, 0, 32'h0);
    @(negedge clk);
    data_read = 1'b1;
    n = 0;
    while (!read && n < 10) begin @(negedge clk); n++; end
    chk("midreset_read_seen", {31'd0, read}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1; data_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_strobes", {30'd0, read, write}, 32'd0);
    chk("midreset_dones", {29'd0, instr_done, data_done, bus_error}, 32'd0);
    chk("midreset_data_readdata", data_readdata, 32'h0);
    instr_address = 32'h0000_0300;
    push_bus(32'h0000_0300, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b0, 1, 2, 32'h6666_6666);
    push_cpl(1'b0, 32'h6666_6666, 1'b0);
    run(1'b1, 0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("bus_queue_drained", bus_q.size(), 32'd0);
    chk("cpl_queue_drained", cpl_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
